result_drain: RTL and testbench
===============================

// Module: result_drain
// PURPOSE
//   Downstream of the single-core top. On the rising edge of end_process it snapshots
//   the core's 16 result registers r1..r16 into shadow storage. It then streams them
//   out one word per handshake, with index, over a valid/ready port.
//   Frees the core to be restarted while results are read out by a host/UART/next core.
// PARAMETERS
//   DATA_W  12  width of each result register
//   N_REG   16  number of result registers captured
//   IDX_W    4  width of word index, >= clog2(N_REG)
// PORTS
//   clk          in   1              system clock, all logic on posedge
//   rst_n        in   1              asynchronous active-low reset
//   end_process  in   1              core finished; level, rising edge triggers capture
//   r_flat       in   N_REG*DATA_W   r1 at [DATA_W-1:0], r2 next, ..., r16 at MSBs
//   out_data     out  DATA_W         current result word
//   out_idx      out  IDX_W          index of out_data (0 = r1)
//   out_valid    out  1              out_data/out_idx valid
//   out_ready    in   1              consumer accepts word when high with out_valid
//   busy         out  1              high from capture until done pulse (inclusive)
//   done         out  1              one-cycle pulse after last word accepted
//   overrun      out  1              sticky: end_process edge arrived while busy
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE; out_data=0, out_idx=0, out_valid=0, busy=0,
//     done=0, overrun=0; shadow regs=0; end_process history reg=0.
//     A level-high end_process at reset release therefore counts as an edge.
//   Edge detect: ep_q <= end_process each cycle; edge = end_process & ~ep_q.
//   FSM states IDLE, SEND, DONE:
//     IDLE: edge -> latch all N_REG words from r_flat, idx=0, go SEND.
//       out_valid=1, busy=1 from the next cycle (latency 1 clk edge->first word).
//     SEND: out_data = shadow[idx].
//       Handshake = out_valid & out_ready, sampled on posedge.
//       Handshake and idx<N_REG-1 -> idx+1.
//       Handshake and idx==N_REG-1 -> out_valid=0, go DONE.
//       No handshake -> out_data/out_idx/out_valid held stable; no timeout.
//     DONE: done=1 and busy=1 for exactly this cycle; next cycle IDLE, busy=0.
//   Edge seen in SEND or DONE: ignored (shadow untouched), overrun<=1.
//     overrun stays set until rst_n. An edge in IDLE on the cycle after DONE is accepted.
//   end_process held high: one capture only; needs a low then high to recapture.
//   r_flat is sampled only at capture; later changes have no effect on streamed data.
//   Full-throughput: out_ready held 1 -> N_REG words on N_REG consecutive cycles.
//     Edge at cycle T: words at T+1..T+N_REG, done at T+N_REG+1.
//   Reset mid-stream: immediate abort, all outputs to reset values; no done pulse.
//   out_idx never exceeds N_REG-1; no wrap within a transfer.
// TESTING
//   1 r_flat words = 1..16, edge, out_ready=1
//     -> out_idx 0..15 / out_data 1..16 on consecutive cycles;
//        done pulse 1 cycle after idx15; busy low the cycle after.
//   2 Same data, out_ready toggling 1,0,0,1,...
//     -> data/idx stable while stalled; no word skipped or duplicated; 16 transfers total.
//   3 Change r_flat to all 12'hFFF one cycle after capture
//     -> streamed words remain 1..16.
//   4 Second end_process edge while idx=5
//     -> overrun=1 and stays 1; stream continues 6..15 with original data.
//   5 end_process held high 40 cycles
//     -> exactly one stream of 16 words and one done pulse.
//   6 Assert rst_n=0 at idx=7, release, pulse end_process with new data 100..115
//     -> outputs cleared during reset; new stream idx 0..15 = 100..115.

Source files
------------

// File: rtl/result_drain.sv
// Snapshots N_REG result words on an end_process rising edge and streams them out with index;
// first word valid 1 clk after the edge; a stalled word is held stable indefinitely while out_ready is low.
module result_drain #(
    parameter int DATA_W = 12,
    parameter int N_REG  = 16,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    end_process,
    input  logic [N_REG*DATA_W-1:0] r_flat,
    output logic [DATA_W-1:0]       out_data,
    output logic [IDX_W-1:0]        out_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun
);
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REG - 1);

    state_t            state;
    state_t            state_nxt;
    logic              ep_q;
    logic              ep_rise;
    logic              capture;
    logic              advance;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] shadow [N_REG];

    // ep_q resets low, so a level-high end_process at reset release counts as an edge
    assign ep_rise  = end_process & ~ep_q;
    assign out_data = shadow[idx];
    assign out_idx  = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (ep_rise) begin
                    capture   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    if (idx == LAST_IDX) begin
                        state_nxt = DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ep_q    <= 1'b0;
            idx     <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < N_REG; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            ep_q <= end_process;
            if (capture) begin
                idx <= '0;
                for (int i = 0; i < N_REG; i++) begin
                    shadow[i] <= r_flat[i*DATA_W +: DATA_W];
                end
            end else if (advance) begin
                idx <= idx + 1'b1;
            end
            // A new result set while still draining is dropped; the host must see it
            if (ep_rise && state != IDLE) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: throughput, stalls, capture isolation, overrun, held level, mid-stream reset.
module tb_result_drain;
    localparam int DATA_W = 12;
    localparam int N_REG  = 16;
    localparam int IDX_W  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    end_process;
    logic [N_REG*DATA_W-1:0] r_flat;
    logic [DATA_W-1:0]       out_data;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_valid;
    logic                    out_ready;
    logic                    busy;
    logic                    done;
    logic                    overrun;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_drain #(.DATA_W(DATA_W), .N_REG(N_REG), .IDX_W(IDX_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .end_process(end_process),
        .r_flat(r_flat),
        .out_data(out_data),
        .out_idx(out_idx),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy(busy),
        .done(done),
        .overrun(overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N_REG*DATA_W-1:0] pack_seq(input int base);
        logic [N_REG*DATA_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_REG; i++) begin
            v[i*DATA_W +: DATA_W] = DATA_W'(base + i);
        end
        return v;
    endfunction

    // Called right after end_process was raised at a negedge. Each iteration is one negedge:
    // drive out_ready, apply scheduled side stimulus, then check the presented word.
    task automatic drain(input int pat, input int base, input int fall_at, input int rise_at,
                         input int flood_at, output int cycles);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < N_REG && cyc < 200) begin
            @(negedge clk);
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 3) == 0);
            if (cyc == fall_at)  end_process = 1'b0;
            if (cyc == rise_at)  end_process = 1'b1;
            if (cyc == flood_at) r_flat = {(N_REG*DATA_W){1'b1}};
            cyc++;
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_busy", 32'(busy), 32'd1);
            check("stream_idx", 32'(out_idx), 32'(cnt));
            check("stream_data", 32'(out_data), 32'(base + cnt));
            check("stream_done_low", 32'(done), 32'd0);
            if (out_valid && out_ready) cnt++;
        end
        check("stream_count", 32'(cnt), 32'(N_REG));
        @(negedge clk);
        out_ready = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd1);
        check("done_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("after_done", 32'(done), 32'd0);
        check("after_busy", 32'(busy), 32'd0);
        cycles = cyc;
    endtask

    initial begin
        int cycles;
        int guard;
        rst_n       = 1'b0;
        end_process = 1'b0;
        out_ready   = 1'b0;
        r_flat      = pack_seq(1);
        repeat (2) @(negedge clk);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_idx", 32'(out_idx), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: full throughput, 16 words on 16 consecutive cycles
        end_process = 1'b1;
        drain(0, 1, 1, -1, -1, cycles);
        check("t1_cycles", 32'(cycles), 32'd16);

        // 2: ready pattern 1,0,0 repeating -> 16th handshake on cycle 46
        end_process = 1'b1;
        drain(1, 1, 1, -1, -1, cycles);
        check("t2_cycles", 32'(cycles), 32'd46);

        // 3: r_flat changes one cycle after capture
        end_process = 1'b1;
        drain(0, 1, 1, -1, 0, cycles);
        check("t3_overrun", 32'(overrun), 32'd0);

        // 4: second edge while idx=5, new data offered at the same time
        r_flat = pack_seq(1);
        end_process = 1'b1;
        drain(0, 1, 1, 5, 5, cycles);
        check("t4_overrun", 32'(overrun), 32'd1);
        end_process = 1'b0;
        r_flat = pack_seq(1);
        @(negedge clk);

        // 5: end_process held high 40 cycles -> one stream only
        end_process = 1'b1;
        drain(0, 1, -1, -1, -1, cycles);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            out_ready = 1'b1;
            check("t5_no_restream", 32'(out_valid), 32'd0);
            check("t5_no_done", 32'(done), 32'd0);
        end
        check("t5_overrun_sticky", 32'(overrun), 32'd1);
        end_process = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // 6: reset mid-stream at idx=7, then new data 100..115
        end_process = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        @(negedge clk);
        while (out_idx != 4'd7 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("t6_reached_idx7", 32'(out_idx), 32'd7);
        rst_n = 1'b0;
        end_process = 1'b0;
        out_ready = 1'b0;
        #1;
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_idx", 32'(out_idx), 32'd0);
        check("t6_rst_data", 32'(out_data), 32'd0);
        check("t6_rst_overrun", 32'(overrun), 32'd0);
        r_flat = pack_seq(100);
        @(negedge clk);
        check("t6_rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_idle_valid", 32'(out_valid), 32'd0);
        end_process = 1'b1;
        drain(0, 100, 1, -1, -1, cycles);
        check("t6_cycles", 32'(cycles), 32'd16);
        check("t6_overrun", 32'(overrun), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
